// File: rtl/arb_mux_n.sv
// arb_mux_n: N-way WIDTH-bit valid/ready merge with round-robin or fixed-priority arbitration.
// Latency: one cycle, from an input transfer to out_valid with that word; 1 word/cycle throughput.
// Backpressure: while the output holds a word and out_ready_i=0, in_ready_o is all zero and the output is frozen.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   in_valid_i   [N]        channel i offers word i
//   in_ready_o   [N]        channel i word accepted this cycle (one-hot or zero)
//   in_data_i    [N*WIDTH]  channel i word at [i*WIDTH +: WIDTH]
//   out_valid_o             output register holds a word
//   out_ready_i             consumer takes the output word this cycle
//   out_data_o   [WIDTH]    registered selected word
//   out_sel_o    [SEL_W]    index of the channel that supplied out_data_o
module arb_mux_n #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter bit RR    = 1'b1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [N-1:0]                     in_valid_i,
  output logic [N-1:0]                     in_ready_o,
  input  logic [N*WIDTH-1:0]               in_data_i,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [WIDTH-1:0]                 out_data_o,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] out_sel_o
);

  localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0] out_sel_q,   out_sel_d;
  logic [SEL_W-1:0] ptr_q,       ptr_d;

  logic             load;
  logic [N-1:0]     gnt;
  logic             gnt_any;
  logic [SEL_W-1:0] gnt_idx;
  logic [SEL_W-1:0] cand;
  logic [WIDTH-1:0] sel_dat;

  // Channel examined k-th in a round-robin search starting just after p.
  // p+1+k never exceeds 2N-1, so one wrap subtraction is enough.
  function automatic logic [SEL_W-1:0] rr_idx(input logic [SEL_W-1:0] p, input int k);
    int t;
    t = int'(p) + 1 + k;
    if (t >= N) t = t - N;
    return t[SEL_W-1:0];
  endfunction

  // Stage can take a new word when empty or when its current word leaves this cycle.
  assign load = ~out_valid_q | out_ready_i;

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    gnt     = '0;
    for (int k = 0; k < N; k++) begin
      cand = RR ? rr_idx(ptr_q, k) : SEL_W'(k);
      if (load && !gnt_any && in_valid_i[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

  assign in_ready_o = gnt;

  // AND-OR select driven by the one-hot grant.
  always_comb begin
    sel_dat = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) sel_dat = sel_dat | in_data_i[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (load) begin
      out_valid_d = gnt_any;
      // Without a transfer the data/sel registers keep their last values.
      if (gnt_any) begin
        out_data_d = sel_dat;
        out_sel_d  = gnt_idx;
        ptr_d      = gnt_idx;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      // Pointer at the last channel so channel 0 wins first after reset.
      ptr_q       <= SEL_W'(N - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_sel_o   = out_sel_q;

endmodule
